// File: rtl/irq_ctrl.sv
// irq_ctrl: four-source edge-detecting interrupt controller with a small
// register file (PENDING, MASK, CLEAR, STATUS) and a request/service
// handshake towards the pipeline hazard unit.
module irq_ctrl #(
    parameter int N_SRC = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_in,
    input  logic [1:0]       bus_addr,
    input  logic             bus_wr,
    input  logic [31:0]      bus_wdata,
    output logic [31:0]      bus_rdata,
    output logic             irq,
    input  logic             irq_ack,
    input  logic             eret,
    output logic [1:0]       cause,
    output logic             in_service
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SERV = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd1;
    localparam logic [1:0] ADDR_CLEAR   = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    state_t           state;
    logic [N_SRC-1:0] src_prev;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] clear_bits;
    logic [N_SRC-1:0] active;

    // Upper write-data bits have no storage behind them.
    logic unused_wdata;
    assign unused_wdata = ^bus_wdata[31:N_SRC];

    // Lowest-numbered active source wins arbitration.
    function automatic logic [1:0] lowest_index(input logic [N_SRC-1:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (v[i]) idx = i[1:0];
        end
        return idx;
    endfunction

    assign rise       = src_in & ~src_prev;
    assign clear_bits = (bus_wr && bus_addr == ADDR_CLEAR) ? bus_wdata[N_SRC-1:0] : '0;
    assign active     = pending & mask;

    // Status outputs are pure decodes of the state register, so no input
    // can reach irq or in_service combinationally.
    assign irq        = (state == REQ);
    assign in_service = (state == SERV);

    // Edge detection, pending capture (set beats clear) and mask register.
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of order.
    always_ff @(posedge clk) begin
        src_prev <= src_in;
        if (reset) begin
            pending <= '0;
            mask    <= '0;
        end else begin
            pending <= (pending & ~clear_bits) | rise;
            if (bus_wr && bus_addr == ADDR_MASK) mask <= bus_wdata[N_SRC-1:0];
        end
    end

    // Request/service FSM; cause is captured on leaving IDLE and held after.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cause <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (active != '0) begin
                        state <= REQ;
                        cause <= lowest_index(active);
                    end
                end
                REQ: begin
                    // Acknowledge beats withdrawal: the pipeline has already
                    // redirected, so the handler must be tracked.
                    if (irq_ack)              state <= SERV;
                    else if (!active[cause])  state <= IDLE;
                end
                SERV: begin
                    if (eret) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Register read mux.
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        bus_rdata = 32'd0;
        case (bus_addr)
            ADDR_PENDING: bus_rdata = {{(32-N_SRC){1'b0}}, pending};
            ADDR_MASK:    bus_rdata = {{(32-N_SRC){1'b0}}, mask};
            ADDR_CLEAR:   bus_rdata = 32'd0;
            ADDR_STATUS:  bus_rdata = {27'd0, state, cause, in_service};
            default:      bus_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl. Inputs change 1 ns after a
// rising edge; outputs are checked at that same point, away from the edge.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  src_in;
    logic [1:0]  bus_addr;
    logic        bus_wr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        irq;
    logic        irq_ack;
    logic        eret;
    logic [1:0]  cause;
    logic        in_service;

    int errors = 0;
    int checks = 0;

    irq_ctrl #(.N_SRC(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .src_in     (src_in),
        .bus_addr   (bus_addr),
        .bus_wr     (bus_wr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .irq        (irq),
        .irq_ack    (irq_ack),
        .eret       (eret),
        .cause      (cause),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus_addr  = a;
        bus_wdata = d;
        bus_wr    = 1'b1;
        tick();
        bus_wr    = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        bus_addr = a;
        #1;
        d = bus_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1; src_in = 4'h0; bus_addr = 2'd0; bus_wr = 1'b0;
        bus_wdata = 32'd0; irq_ack = 1'b0; eret = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
        checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL reset_in_service got=%b exp=0", in_service); end
        checks++; if (cause !== 2'd0) begin errors++; $display("FAIL reset_cause got=%0d exp=0", cause); end
        bus_read(2'd0, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_pending got=%h exp=0", d); end
        bus_read(2'd1, d);
        checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_mask got=%h exp=0", d); end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        bus_write(2'd1, 32'hFFFF_FFF5);
        bus_read(2'd1, d);
        checks++; if (d !== 32'h5) begin errors++; $display("FAIL mask_upper_ignored got=%h exp=5", d); end
        bus_write(2'd1, 32'hF);
        src_in = 4'h2;
        tick();                          // edge k samples the rise
        src_in = 4'h0;
        bus_read(2'd0, d);
        checks++; if (d !== 32'h2) begin errors++; $display("FAIL basic_pending got=%h exp=2", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL basic_irq_early got=%b exp=0", irq); end
        tick();                          // edge k+1 enters REQ
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL basic_irq got=%b exp=1", irq); end
        checks++; if (cause !== 2'd1) begin errors++; $display("FAIL basic_cause got=%0d exp=1", cause); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        checks++; if (in_service !== 1'b1 || irq !== 1'b0) begin
            errors++; $display("FAIL basic_ack got in_service=%b irq=%b exp 1/0", in_service, irq); end
        bus_read(2'd3, d);
        checks++; if (d !== 32'd19) begin errors++; $display("FAIL basic_status got=%0d exp=19", d); end
        bus_write(2'd2, 32'h2);
        bus_read(2'd0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL basic_clear got=%h exp=0", d); end
        eret = 1'b1; tick(); eret = 1'b0;
        tick();
        checks++; if (in_service !== 1'b0 || irq !== 1'b0) begin
            errors++; $display("FAIL basic_eret got in_service=%b irq=%b exp 0/0", in_service, irq); end
    endtask

    task automatic test_priority();
        logic [31:0] d;
        src_in = 4'h9;
        tick();
        src_in = 4'h0;
        tick();
        checks++; if (irq !== 1'b1 || cause !== 2'd0) begin
            errors++; $display("FAIL prio_first got irq=%b cause=%0d exp 1/0", irq, cause); end
        eret = 1'b1; tick(); eret = 1'b0;    // eret outside SERV is ignored
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL prio_eret_ignored got=%b exp=1", irq); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        eret = 1'b1; tick(); eret = 1'b0;
        checks++; if (irq !== 1'b0 || in_service !== 1'b0) begin
            errors++; $display("FAIL prio_idle got irq=%b in_service=%b exp 0/0", irq, in_service); end
        tick();
        checks++; if (irq !== 1'b1 || cause !== 2'd0) begin
            errors++; $display("FAIL prio_reenter got irq=%b cause=%0d exp 1/0", irq, cause); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        bus_write(2'd2, 32'h1);
        bus_read(2'd0, d);
        checks++; if (d !== 32'h8) begin errors++; $display("FAIL prio_pending got=%h exp=8", d); end
        eret = 1'b1; tick(); eret = 1'b0;
        tick();
        checks++; if (irq !== 1'b1 || cause !== 2'd3) begin
            errors++; $display("FAIL prio_next got irq=%b cause=%0d exp 1/3", irq, cause); end
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        bus_write(2'd2, 32'h8);
        eret = 1'b1; tick(); eret = 1'b0;
        tick();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;  // ack outside REQ is ignored
        checks++; if (in_service !== 1'b0 || irq !== 1'b0) begin
            errors++; $display("FAIL prio_ack_ignored got in_service=%b irq=%b exp 0/0", in_service, irq); end
        checks++; if (cause !== 2'd3) begin errors++; $display("FAIL prio_cause_hold got=%0d exp=3", cause); end
    endtask

    task automatic test_masked();
        logic [31:0] d;
        bus_write(2'd1, 32'h0);
        bus_addr = 2'd2; bus_wdata = 32'h4; bus_wr = 1'b1; src_in = 4'h4;
        tick();                          // set and clear on the same edge
        bus_wr = 1'b0; src_in = 4'h0;
        bus_read(2'd0, d);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL set_wins got=%h exp=4", d); end
        bus_write(2'd0, 32'h0);
        bus_write(2'd3, 32'hFFFF_FFFF);
        bus_read(2'd0, d);
        checks++; if (d !== 32'h4) begin errors++; $display("FAIL ro_writes got=%h exp=4", d); end
        bus_read(2'd2, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL clear_read got=%h exp=0", d); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL masked_irq got=%b exp=0", irq); end
        bus_write(2'd1, 32'h4);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL unmask_early got=%b exp=0", irq); end
        tick();
        checks++; if (irq !== 1'b1 || cause !== 2'd2) begin
            errors++; $display("FAIL unmask_irq got irq=%b cause=%0d exp 1/2", irq, cause); end
    endtask

    task automatic test_withdraw();
        logic [31:0] d;
        bus_write(2'd2, 32'h4);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL withdraw_hold got=%b exp=1", irq); end
        tick();
        bus_read(2'd3, d);
        checks++; if (irq !== 1'b0 || d[4:3] !== 2'd0) begin
            errors++; $display("FAIL withdraw got irq=%b state=%0d exp 0/0", irq, d[4:3]); end
        src_in = 4'h4; tick(); src_in = 4'h0;
        tick();
        checks++; if (irq !== 1'b1 || cause !== 2'd2) begin
            errors++; $display("FAIL withdraw_rereq got irq=%b cause=%0d exp 1/2", irq, cause); end
        bus_write(2'd2, 32'h4);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;  // ack meets withdrawal
        bus_read(2'd3, d);
        checks++; if (in_service !== 1'b1 || d[4:3] !== 2'd2) begin
            errors++; $display("FAIL ack_wins got in_service=%b state=%0d exp 1/2", in_service, d[4:3]); end
        eret = 1'b1; tick(); eret = 1'b0;
    endtask

    task automatic test_reset_cases();
        logic [31:0] d;
        src_in = 4'h1; reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick(); tick();
        bus_read(2'd0, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL held_src_pending got=%h exp=0", d); end
        bus_write(2'd1, 32'h1);
        src_in = 4'h0; tick();
        src_in = 4'h1; tick();
        tick();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL pre_reset_serv got=%b exp=1", in_service); end
        reset = 1'b1; tick(); reset = 1'b0;
        bus_read(2'd0, d);
        checks++; if (in_service !== 1'b0 || irq !== 1'b0 || d !== 32'h0) begin
            errors++; $display("FAIL reset_serv got in_service=%b irq=%b pending=%h exp 0/0/0", in_service, irq, d); end
        src_in = 4'h0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_masked();
        test_withdraw();
        test_reset_cases();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter N_SRC, default 4, number of interrupt sources; fixed at 4 for this release.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 src_in  input  4  raw level interrupt sources (bit0 timer, bit1 UART RX, bit2 UART TX, bit3 external).
REQ-005 bus_addr  input  2  register select: 0 PENDING, 1 MASK, 2 CLEAR, 3 STATUS.
REQ-006 bus_wr  input  1  write strobe, one cycle per write.
REQ-007 bus_wdata  input  32  write data.
REQ-008 bus_rdata  output  32  combinational read data for bus_addr.
REQ-009 irq  output  1  registered interrupt request to the pipeline hazard unit.
REQ-010 irq_ack  input  1  one-cycle pulse: pipeline has redirected PC to the handler.
REQ-011 eret  input  1  one-cycle pulse: handler return executed.
REQ-012 cause  output  2  index of the source being requested or serviced.
REQ-013 in_service  output  1  high while a handler runs.

Function
REQ-014 The block SHALL keep src_prev[3:0], the value of src_in sampled at the previous edge.
REQ-015 At an edge where src_in[i]=1 and src_prev[i]=0, pending[i] SHALL be set, visible the following cycle.
REQ-016 A write of 1 to bit i at CLEAR SHALL clear pending[i]; if an edge on bit i occurs the same cycle, set SHALL win.
REQ-017 MASK[3:0] SHALL be read/write; bits 31:4 ignored on write, read as 0.
REQ-018 Reads: PENDING={28'b0,pending}; MASK={28'b0,mask}; CLEAR=0; STATUS={27'b0,state[1:0],cause,in_service} laid out as bit0 in_service, bits2:1 cause, bits4:3 state code.
REQ-019 Writes to PENDING and STATUS SHALL have no effect.
REQ-020 FSM states SHALL be IDLE(0), REQ(1), SERV(2); code 3 unreachable and SHALL return to IDLE next cycle.
REQ-021 IDLE: if (pending & mask)!=0, next state REQ and cause latched as lowest set index of (pending & mask).
REQ-022 REQ: irq=1; if irq_ack, next state SERV; else if pending[cause]&mask[cause]==0, next state IDLE (request withdrawn, irq drops next cycle).
REQ-023 If irq_ack and withdrawal coincide in REQ, irq_ack SHALL win (go SERV).
REQ-024 SERV: irq=0, in_service=1; on eret next state IDLE; new pending bits accumulate but no nesting.
REQ-025 irq_ack outside REQ and eret outside SERV SHALL be ignored.
REQ-026 cause SHALL stay constant throughout REQ and SERV; in IDLE it holds its last value.
REQ-027 Latency: rising edge sampled at edge k, mask set -> pending at k, REQ entered at k+1, irq high in cycle after edge k+1 (two edges).
REQ-028 After eret, if (pending & mask)!=0, REQ SHALL be re-entered one edge after return to IDLE; pending is not auto-cleared by ack or eret.
REQ-029 irq and in_service SHALL be decoded from registered state only (no combinational path from inputs).

Reset
REQ-030 On reset: state=IDLE, pending=0, mask=0, cause=0, irq=0, in_service=0.
REQ-031 During reset src_prev SHALL load src_in, so a source held high through reset produces no edge.
REQ-032 Reset mid-REQ or mid-SERV SHALL abort to IDLE the next cycle, discarding the in-flight request.

Verification
REQ-033 mask=0xF, pulse src_in[1] -> pending=0x2 next cycle, irq=1 two edges after sample, cause=1; irq_ack -> in_service=1, irq=0.
REQ-034 mask=0xF, src_in[3] and src_in[0] rise same cycle -> cause=0; after eret without clear, REQ re-entered with cause=0 again; write CLEAR=0x1 then eret -> next cause=3.
REQ-035 mask=0x0, edge on src_in[2] -> pending=0x4, irq stays 0; write MASK=0x4 -> irq=1 two edges later.
REQ-036 In REQ with cause=2, write CLEAR=0x4 with no ack -> state IDLE, irq=0 next cycle; repeat with irq_ack same cycle -> SERV.
REQ-037 src_in[0] held high across reset release -> pending stays 0; reset asserted during SERV -> in_service=0, pending=0 next cycle.
